multicycle_ctrl: RTL and testbench

//  Multicycle sequencer for the RV32 core: steps each instruction through FETCH, DECODE, EXEC,

---
 rtl/multicycle_ctrl.sv | 293 +++++++++++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
//-----------------------------------------------------------------------------
// multicycle_ctrl
//
// Multicycle sequencer for the RV32 core. Every instruction walks through
// FETCH -> DECODE -> EXEC -> [MEM] -> WB. The sequencer drives the decoder
// enable, the IR/PC/register-file write strobes and the req/ack handshakes
// to instruction and data memory. It uses the decoder's type flags.
//
// Optional feature macro: MC_ILLEGAL_TRAP_EN
//   defined   : an instruction with no type flag set leaves DECODE for a
//               one-cycle TRAP state (pc_we=1, pc_sel=11, trap pulse) and
//               does not retire.
//   undefined : there is no trap port. Such an instruction runs EXEC -> WB as
//               a NOP (no rf write, pc+4, retires).
//
// Parameters
//   TIMEOUT_W  width of the memory-wait counter
//   TIMEOUT    number of unacked request cycles before a bus error
//              (must be < 2**TIMEOUT_W)
//
// Ports
//   clk, rst            clock (rising edge), synchronous active-high reset
//   imem_req / imem_ack instruction fetch handshake
//   dmem_req / dmem_we / dmem_ack
//                       data access handshake (dmem_we=1 for a store)
//   ir_we               latch the fetched word (same cycle as imem_ack)
//   decode_en, exec_en  one-cycle enables for the decoder and the ALU
//   rf_we, pc_we        write-back strobes
//   pc_sel              00 pc+4, 01 branch, 10 jal/jalr, 11 trap vector
//   is_*_instr, is_lui, rd_valid
//                       decoder outputs, held stable from DECODE to WB
//   br_taken            branch compare result, valid in EXEC and WB
//   busy                high in every state except IDLE and ERR
//   bus_err             sticky memory-timeout flag
//   instret             retired-instruction counter (wraps)
//   trap                (MC_ILLEGAL_TRAP_EN only) one-cycle illegal pulse
//-----------------------------------------------------------------------------
module multicycle_ctrl #(
  parameter int TIMEOUT_W = 8,
  parameter int TIMEOUT   = 200
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  input  logic        imem_ack,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ack,
  output logic        ir_we,
  output logic        decode_en,
  output logic        exec_en,
  output logic        rf_we,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  input  logic        is_i_instr,
  input  logic        is_r_instr,
  input  logic        is_s_instr,
  input  logic        is_l_instr,
  input  logic        is_b_instr,
  input  logic        is_j_instr,
  input  logic        is_jr_instr,
  input  logic        is_u_instr,
  input  logic        is_lui,
  input  logic        rd_valid,
  input  logic        br_taken,
  output logic        busy,
  output logic        bus_err,
  output logic [31:0] instret
`ifdef MC_ILLEGAL_TRAP_EN
  , output logic      trap
`endif
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6,
    S_ERR    = 3'd7
  } state_t;

  typedef enum logic [1:0] {
    PC_PLUS4  = 2'b00,
    PC_BRANCH = 2'b01,
    PC_JUMP   = 2'b10,
    PC_TRAP   = 2'b11
  } pc_sel_t;

  localparam logic [TIMEOUT_W-1:0] TIMEOUT_CNT = TIMEOUT_W'(TIMEOUT);

  state_t               r_state;
  logic [TIMEOUT_W-1:0] r_count;
  logic                 r_imem_req;
  logic                 r_dmem_req;
  logic                 r_dmem_we;
  logic                 r_decode_en;
  logic                 r_exec_en;
  logic                 r_rf_we;
  logic                 r_pc_we;
  pc_sel_t              r_pc_sel;
  logic                 r_busy;
  logic                 r_bus_err;
  logic [31:0]          r_instret;
`ifdef MC_ILLEGAL_TRAP_EN
  logic                 r_trap;
`endif

  logic                 w_illegal;
  logic                 w_is_mem;
  logic                 w_rf_we_wb;
  logic [TIMEOUT_W-1:0] w_count_inc;
  logic                 w_timeout;
  pc_sel_t              w_wb_sel;

  // An instruction the decoder could not classify raises no type flag.
  assign w_illegal   = ~|{is_i_instr, is_r_instr, is_s_instr, is_l_instr,
                          is_b_instr, is_j_instr, is_jr_instr, is_u_instr,
                          is_lui};
  assign w_is_mem    = is_l_instr | is_s_instr;
  // An illegal instruction never writes rd, even if rd_valid glitches high.
  assign w_rf_we_wb  = rd_valid & ~w_illegal;
  assign w_count_inc = r_count + TIMEOUT_W'(1);
  // The current cycle is the TIMEOUT-th unacked one; an ack in it still wins.
  assign w_timeout   = (w_count_inc == TIMEOUT_CNT);

  // Write-back PC source; jumps take priority over a taken branch.
  always_comb begin
    // NOTE: default first so every path assigns w_wb_sel and no latch is inferred.
    w_wb_sel = PC_PLUS4;
    if (is_j_instr | is_jr_instr)
      w_wb_sel = PC_JUMP;
    else if (is_b_instr & br_taken)
      w_wb_sel = PC_BRANCH;
  end

  // State and all strobes are registered together: each branch below sets the
  // outputs that belong to the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: non-blocking assignments for all state so every register samples
      // pre-edge values, independent of statement order.
      r_state     <= S_IDLE;
      r_count     <= '0;
      r_imem_req  <= 1'b0;
      r_dmem_req  <= 1'b0;
      r_dmem_we   <= 1'b0;
      r_decode_en <= 1'b0;
      r_exec_en   <= 1'b0;
      r_rf_we     <= 1'b0;
      r_pc_we     <= 1'b0;
      r_pc_sel    <= PC_PLUS4;
      r_busy      <= 1'b0;
      r_bus_err   <= 1'b0;
      r_instret   <= '0;
`ifdef MC_ILLEGAL_TRAP_EN
      r_trap      <= 1'b0;
`endif
    end else begin
      // One-cycle strobes drop unless the next state raises them again.
      r_decode_en <= 1'b0;
      r_exec_en   <= 1'b0;
      r_rf_we     <= 1'b0;
      r_pc_we     <= 1'b0;
      r_pc_sel    <= PC_PLUS4;
`ifdef MC_ILLEGAL_TRAP_EN
      r_trap      <= 1'b0;
`endif

      case (r_state)
        S_IDLE: begin
          r_state    <= S_FETCH;
          r_imem_req <= 1'b1;
          r_count    <= '0;
          r_busy     <= 1'b1;
        end

        S_FETCH: begin
          if (imem_ack) begin
            r_state     <= S_DECODE;
            r_imem_req  <= 1'b0;
            r_decode_en <= 1'b1;
          end else if (w_timeout) begin
            r_state    <= S_ERR;
            r_imem_req <= 1'b0;
            r_busy     <= 1'b0;
            r_bus_err  <= 1'b1;
          end else begin
            r_count <= w_count_inc;
          end
        end

        S_DECODE: begin
`ifdef MC_ILLEGAL_TRAP_EN
          if (w_illegal) begin
            r_state  <= S_TRAP;
            r_pc_we  <= 1'b1;
            r_pc_sel <= PC_TRAP;
            r_trap   <= 1'b1;
          end else begin
            r_state   <= S_EXEC;
            r_exec_en <= 1'b1;
          end
`else
          r_state   <= S_EXEC;
          r_exec_en <= 1'b1;
`endif
        end

        S_EXEC: begin
          if (w_is_mem) begin
            r_state    <= S_MEM;
            r_dmem_req <= 1'b1;
            r_dmem_we  <= is_s_instr;
            r_count    <= '0;
          end else begin
            r_state  <= S_WB;
            r_pc_we  <= 1'b1;
            r_rf_we  <= w_rf_we_wb;
            r_pc_sel <= w_wb_sel;
          end
        end

        S_MEM: begin
          if (dmem_ack) begin
            r_state    <= S_WB;
            r_dmem_req <= 1'b0;
            r_dmem_we  <= 1'b0;
            r_pc_we    <= 1'b1;
            r_rf_we    <= w_rf_we_wb;
            r_pc_sel   <= w_wb_sel;
          end else if (w_timeout) begin
            r_state    <= S_ERR;
            r_dmem_req <= 1'b0;
            r_dmem_we  <= 1'b0;
            r_busy     <= 1'b0;
            r_bus_err  <= 1'b1;
          end else begin
            r_count <= w_count_inc;
          end
        end

        S_WB: begin
          r_state    <= S_FETCH;
          r_imem_req <= 1'b1;
          r_count    <= '0;
          r_instret  <= r_instret + 32'd1;
        end

        S_TRAP: begin
          r_state    <= S_FETCH;
          r_imem_req <= 1'b1;
          r_count    <= '0;
        end

        S_ERR: begin
          // Sticky until reset: everything stays quiet.
          r_state <= S_ERR;
        end

        default: begin
          r_state    <= S_IDLE;
          r_imem_req <= 1'b0;
          r_dmem_req <= 1'b0;
          r_dmem_we  <= 1'b0;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  // ir_we follows the ack combinationally so IR captures the word in the
  // same cycle the memory presents it; r_imem_req is high only in FETCH.
  assign ir_we     = r_imem_req & imem_ack;

  assign imem_req  = r_imem_req;
  assign dmem_req  = r_dmem_req;
  assign dmem_we   = r_dmem_we;
  assign decode_en = r_decode_en;
  assign exec_en   = r_exec_en;
  assign rf_we     = r_rf_we;
  assign pc_we     = r_pc_we;
  assign pc_sel    = r_pc_sel;
  assign busy      = r_busy;
  assign bus_err   = r_bus_err;
  assign instret   = r_instret;
`ifdef MC_ILLEGAL_TRAP_EN
  assign trap      = r_trap;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
//-----------------------------------------------------------------------------
// tb_multicycle_ctrl
//
// A list of per-cycle records {inputs, expected outputs} is built up front.
// Directed instructions come first, then random ones. For each instruction
// the expected waveform comes from the sequencing rules: so many FETCH cycles,
// then DECODE, EXEC, optional MEM cycles, and WB. A simple retired count
// gives the expected instret. The records are then applied and compared one
// per cycle. Inputs change on the falling edge. Outputs are sampled 1 time
// unit later, before the next rising edge.
//-----------------------------------------------------------------------------
module tb_multicycle_ctrl;

  localparam int TO = 200;

  // Flag bit positions in the packed flag vector.
  localparam int FI = 0, FR = 1, FS = 2, FL = 3, FB = 4, FJ = 5, FJR = 6, FU = 7, FLUI = 8;

  typedef struct packed {
    logic        imem_req;
    logic        dmem_req;
    logic        dmem_we;
    logic        ir_we;
    logic        decode_en;
    logic        exec_en;
    logic        rf_we;
    logic        pc_we;
    logic [1:0]  pc_sel;
    logic        busy;
    logic        bus_err;
    logic        trap;
    logic [31:0] instret;
  } outs_t;

  typedef struct {
    logic       rst;
    logic       imem_ack;
    logic       dmem_ack;
    logic [8:0] flags;
    logic       rd_valid;
    logic       br_taken;
    bit         chk;
    outs_t      exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst, imem_ack, dmem_ack, rd_valid, br_taken;
  logic [8:0] flags;
  logic imem_req, dmem_req, dmem_we, ir_we, decode_en, exec_en, rf_we, pc_we;
  logic [1:0] pc_sel;
  logic busy, bus_err, trap;
  logic [31:0] instret;

  always #5 clk = ~clk;

  multicycle_ctrl #(.TIMEOUT_W(8), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_ack(imem_ack),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
    .ir_we(ir_we), .decode_en(decode_en), .exec_en(exec_en),
    .rf_we(rf_we), .pc_we(pc_we), .pc_sel(pc_sel),
    .is_i_instr(flags[FI]), .is_r_instr(flags[FR]), .is_s_instr(flags[FS]),
    .is_l_instr(flags[FL]), .is_b_instr(flags[FB]), .is_j_instr(flags[FJ]),
    .is_jr_instr(flags[FJR]), .is_u_instr(flags[FU]), .is_lui(flags[FLUI]),
    .rd_valid(rd_valid), .br_taken(br_taken),
    .busy(busy), .bus_err(bus_err), .instret(instret)
`ifdef MC_ILLEGAL_TRAP_EN
    , .trap(trap)
`endif
  );

`ifndef MC_ILLEGAL_TRAP_EN
  assign trap = 1'b0;
`endif

  vec_t       vq[$];
  int         m_ret;
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [8:0] g_flags;
  logic       g_rdv, g_br;

  // Ack noise on cycles where the ack must be ignored.
  function automatic logic nz();
    return ($urandom_range(0, 3) == 0);
  endfunction

  function automatic outs_t base();
    outs_t o;
    o = '0;
    o.busy    = 1'b1;
    o.instret = 32'(m_ret);
    return o;
  endfunction

  function automatic string fmt(input outs_t o);
    return $sformatf("ireq=%b dreq=%b dwe=%b ir=%b dec=%b ex=%b rf=%b pcwe=%b sel=%b busy=%b err=%b trap=%b ret=%0d",
                     o.imem_req, o.dmem_req, o.dmem_we, o.ir_we, o.decode_en, o.exec_en,
                     o.rf_we, o.pc_we, o.pc_sel, o.busy, o.bus_err, o.trap, o.instret);
  endfunction

  task automatic push(input logic r, input logic ia, input logic da, input bit chk, input outs_t e);
    vec_t v;
    v.rst      = r;
    v.imem_ack = ia;
    v.dmem_ack = da;
    v.flags    = g_flags;
    v.rd_valid = g_rdv;
    v.br_taken = g_br;
    v.chk      = chk;
    v.exp      = e;
    vq.push_back(v);
  endtask

  // Two reset cycles. The first is unchecked because the prior state is
  // arbitrary. The second shows the reset state. Then one IDLE cycle with
  // stray acks.
  task automatic add_reset();
    outs_t z;
    z = '0;
    g_flags = '0; g_rdv = 1'b0; g_br = 1'b0;
    push(1'b1, 1'b0, 1'b0, 1'b0, z);
    m_ret = 0;
    push(1'b1, 1'b0, 1'b0, 1'b1, z);
    push(1'b0, nz(), nz(), 1'b1, z);
  endtask

  task automatic add_err(input int n);
    outs_t e;
    e = '0;
    e.bus_err = 1'b1;
    e.instret = 32'(m_ret);
    for (int i = 0; i < n; i++) push(1'b0, nz(), nz(), 1'b1, e);
  endtask

  // fw / mw = unacked FETCH / MEM cycles before the ack (>= TO means timeout).
  // rst_mem >= 0 asserts reset on that MEM cycle.
  task automatic add_instr(input logic [8:0] f, input logic rdv, input logic br,
                           input int fw, input int mw, input int rst_mem);
    outs_t e;
    logic  legal, mem, last;
    g_flags = f; g_rdv = rdv; g_br = br;
    legal = |f;
    mem   = f[FL] | f[FS];
    for (int i = 0; i < fw && i < TO; i++) begin
      e = base(); e.imem_req = 1'b1;
      push(1'b0, 1'b0, nz(), 1'b1, e);
    end
    if (fw >= TO) begin add_err(6); return; end
    e = base(); e.imem_req = 1'b1; e.ir_we = 1'b1;
    push(1'b0, 1'b1, nz(), 1'b1, e);
    e = base(); e.decode_en = 1'b1;
    push(1'b0, nz(), nz(), 1'b1, e);
`ifdef MC_ILLEGAL_TRAP_EN
    if (!legal) begin
      e = base(); e.pc_we = 1'b1; e.pc_sel = 2'b11; e.trap = 1'b1;
      push(1'b0, nz(), nz(), 1'b1, e);
      return;
    end
`endif
    e = base(); e.exec_en = 1'b1;
    push(1'b0, nz(), nz(), 1'b1, e);
    if (mem) begin
      for (int i = 0; i <= mw && i < TO; i++) begin
        last = (i == mw);
        e = base(); e.dmem_req = 1'b1; e.dmem_we = f[FS];
        if (i == rst_mem) begin
          push(1'b1, nz(), 1'b0, 1'b1, e);
          m_ret = 0;
          e = '0;
          push(1'b0, nz(), nz(), 1'b1, e);
          return;
        end
        push(1'b0, nz(), last, 1'b1, e);
      end
      if (mw >= TO) begin add_err(6); return; end
    end
    e = base(); e.pc_we = 1'b1; e.rf_we = rdv & legal;
    e.pc_sel = (f[FJ] | f[FJR]) ? 2'b10 : ((f[FB] & br) ? 2'b01 : 2'b00);
    push(1'b0, nz(), nz(), 1'b1, e);
    m_ret++;
  endtask

  function automatic logic [8:0] one(input int b);
    logic [8:0] f;
    f = '0;
    if (b < 9) f[b] = 1'b1;
    return f;
  endfunction

  task automatic check(input int k, input outs_t e);
    outs_t a;
    a = '0;
    a.imem_req = imem_req;  a.dmem_req = dmem_req;   a.dmem_we = dmem_we;
    a.ir_we    = ir_we;     a.decode_en = decode_en; a.exec_en = exec_en;
    a.rf_we    = rf_we;     a.pc_we    = pc_we;      a.pc_sel  = pc_sel;
    a.busy     = busy;      a.bus_err  = bus_err;    a.trap    = trap;
    a.instret  = instret;
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL cyc%0d act: %s", k, fmt(a));
      $display("FAIL cyc%0d req: %s", k, fmt(e));
    end
  endtask

  initial begin
    logic [8:0] f;
    int         b, fw, mw;

    rst = 1'b1; imem_ack = 1'b0; dmem_ack = 1'b0;
    flags = '0; rd_valid = 1'b0; br_taken = 1'b0;
    m_ret = 0;

    // Directed sequences.
    add_reset();
    add_instr(one(FR),  1'b1, 1'b0, 0, 0, -1);            // ADD, minimal latency
    add_instr(one(FL),  1'b1, 1'b0, 0, 2, -1);            // LW, dmem ack on 3rd cycle
    add_instr(one(FS),  1'b0, 1'b0, 1, 0, -1);            // SW
    add_instr(one(FB),  1'b0, 1'b1, 0, 0, -1);            // BEQ taken
    add_instr(one(FB),  1'b0, 1'b0, 2, 0, -1);            // BEQ not taken
    add_instr(one(FJ),  1'b1, 1'b1, 0, 0, -1);            // JAL beats br_taken
    add_instr(one(FJR), 1'b1, 1'b0, 0, 0, -1);            // JALR
    add_instr(one(FU) | one(FLUI), 1'b1, 1'b0, 0, 0, -1); // LUI
    add_instr(9'b0,     1'b0, 1'b1, 1, 0, -1);            // illegal
    add_instr(one(FI),  1'b1, 1'b0, TO - 1, 0, -1);       // ack on the TIMEOUT cycle
    add_instr(one(FL),  1'b1, 1'b0, 0, TO - 1, -1);       // ack on the TIMEOUT cycle
    add_instr(one(FR),  1'b1, 1'b0, TO, 0, -1);           // fetch timeout -> ERR
    add_reset();
    add_instr(one(FR),  1'b1, 1'b0, 0, 0, -1);
    add_instr(one(FL),  1'b1, 1'b0, 0, 3, 1);             // reset during MEM
    add_instr(one(FS),  1'b0, 1'b0, 0, TO, -1);           // store timeout -> ERR
    add_reset();

    // Random instructions.
    for (int n = 0; n < 150; n++) begin
      b  = int'($urandom_range(0, 10));
      f  = (b == 10) ? (one(FU) | one(FLUI)) : one(b);
      fw = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6)) : 0;
      mw = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 5)) : 0;
      add_instr(f, (|f) ? 1'($urandom_range(0, 1)) : 1'b0, 1'($urandom_range(0, 1)), fw, mw, -1);
    end
    add_reset();

    // Apply and compare.
    @(negedge clk);
    for (int k = 0; k < vq.size(); k++) begin
      rst      = vq[k].rst;
      imem_ack = vq[k].imem_ack;
      dmem_ack = vq[k].dmem_ack;
      flags    = vq[k].flags;
      rd_valid = vq[k].rd_valid;
      br_taken = vq[k].br_taken;
      #1;
      if (vq[k].chk) check(k, vq[k].exp);
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
